// File: rtl/tx_fifo_ctrl.sv
// Transmit FIFO plus dispatch FSM: buffers host bytes and hands them one at a time
// to TX_FSM through the start/busy handshake.
module tx_fifo_ctrl #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  localparam int unsigned PtrW      = $clog2(FIFO_DEPTH),
  localparam int unsigned CntW      = PtrW + 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [DATA_BITS-1:0] Tx_Data_Wr,
  input  logic                 Write_Req,
  input  logic                 Tx_Busy,
  output logic [DATA_BITS-1:0] Tx_Data_Out,
  output logic                 Transmit_Start_Out,
  output logic                 Tx_FIFO_Empty,
  output logic                 Tx_FIFO_Full,
  output logic                 Tx_FIFO_Overflow,
  output logic [CntW-1:0]      Tx_Count,
  output logic                 Tx_Idle
);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StStart    = 2'd1;
  localparam logic [1:0] StWaitDone = 2'd2;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q, count_d;
  logic [1:0]           state_q, state_d;
  logic [DATA_BITS-1:0] data_out_q;
  logic                 empty_q, full_q, ovf_q;
  logic                 wr_en, pop;

  assign wr_en = Write_Req && !full_q;
  // Pop is gated on the registered count, so a write into an empty FIFO never falls through.
  assign pop   = (state_q == StIdle) && (count_q != '0) && !Tx_Busy;

  always_comb begin
    count_d = count_q;
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (pop) state_d = StStart;
      StStart:    if (Tx_Busy) state_d = StWaitDone;
      StWaitDone: if (!Tx_Busy) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= Tx_Data_Wr;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= StIdle;
      data_out_q <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CntW'(FIFO_DEPTH));
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        data_out_q <= mem_q[rd_ptr_q];
        rd_ptr_q   <= rd_ptr_q + PtrW'(1);
      end
      if (Write_Req && full_q) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign Tx_Data_Out        = data_out_q;
  assign Transmit_Start_Out = (state_q == StStart);
  assign Tx_FIFO_Empty      = empty_q;
  assign Tx_FIFO_Full       = full_q;
  assign Tx_FIFO_Overflow   = ovf_q;
  assign Tx_Count           = count_q;
  assign Tx_Idle            = (count_q == '0) && (state_q == StIdle) && !Tx_Busy;

endmodule

// File: tb/tb_tx_fifo_ctrl.sv
// Directed bench for tx_fifo_ctrl: expected characters are queued as they are written
// and checked in order each time the DUT raises its start request.
module tb_tx_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] wr_data;
  logic       write_req;
  logic       busy_force;
  logic       model_en;
  logic       model_busy;
  logic [1:0] model_cnt;
  logic       tx_busy;
  logic [7:0] tx_data_out;
  logic       start;
  logic       empty, full, ovf, idle;
  logic [3:0] count;

  int vectors     = 0;
  int miscompares = 0;
  int starts      = 0;
  logic [7:0] sb[$];
  logic [7:0] last_data = 8'h00;
  logic       prev_start = 1'b0;

  always #5 clk = ~clk;

  assign tx_busy = busy_force | model_busy;

  tx_fifo_ctrl #(
    .DATA_BITS (8),
    .FIFO_DEPTH(8)
  ) dut (
    .Clk               (clk),
    .Rst               (rst_n),
    .Tx_Data_Wr        (wr_data),
    .Write_Req         (write_req),
    .Tx_Busy           (tx_busy),
    .Tx_Data_Out       (tx_data_out),
    .Transmit_Start_Out(start),
    .Tx_FIFO_Empty     (empty),
    .Tx_FIFO_Full      (full),
    .Tx_FIFO_Overflow  (ovf),
    .Tx_Count          (count),
    .Tx_Idle           (idle)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Simple TX_FSM stand-in: goes busy one cycle after seeing start, stays busy 3 cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_busy <= 1'b0;
      model_cnt  <= 2'd0;
    end else if (model_busy) begin
      if (model_cnt == 2'd0) model_busy <= 1'b0;
      else model_cnt <= model_cnt - 2'd1;
    end else if (model_en && start) begin
      model_busy <= 1'b1;
      model_cnt  <= 2'd2;
    end
  end

  always @(negedge clk) begin
    if (start && !prev_start) begin
      starts++;
      vectors++;
      assert (sb.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_start observed_data=0x%0h expected=no_start", tx_data_out);
      end
      if (sb.size() != 0) begin
        last_data = sb.pop_front();
        chk("tx_order", {24'h0, tx_data_out}, {24'h0, last_data});
      end
    end else if (start) begin
      chk("tx_hold", {24'h0, tx_data_out}, {24'h0, last_data});
    end
    prev_start <= start;
  end

  task automatic wait_drain(input string tag);
    int n = 0;
    while (!(sb.size() == 0 && idle === 1'b1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'h0, (sb.size() == 0 && idle === 1'b1)}, 32'h1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    write_req  = 1'b1;
    wr_data    = 8'h55;
    busy_force = 1'b0;
    model_en   = 1'b0;

    // Reset held with a pending write
    repeat (3) @(negedge clk);
    chk("rst_empty", {31'h0, empty}, 32'h1);
    chk("rst_full", {31'h0, full}, 32'h0);
    chk("rst_ovf", {31'h0, ovf}, 32'h0);
    chk("rst_count", {28'h0, count}, 32'h0);
    chk("rst_start", {31'h0, start}, 32'h0);
    chk("rst_idle", {31'h0, idle}, 32'h1);
    chk("rst_data", {24'h0, tx_data_out}, 32'h0);
    write_req = 1'b0;
    rst_n     = 1'b1;

    // Single character with a CTS-style stall
    @(negedge clk);
    write_req = 1'b1;
    wr_data   = 8'hA5;
    sb.push_back(8'hA5);
    @(negedge clk);
    write_req = 1'b0;
    chk("single_count", {28'h0, count}, 32'h1);
    chk("single_empty", {31'h0, empty}, 32'h0);
    chk("single_start_pre", {31'h0, start}, 32'h0);
    @(negedge clk);
    chk("single_start_n1", {31'h0, start}, 32'h1);
    chk("single_count_pop", {28'h0, count}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("single_start_stall", {31'h0, start}, 32'h1);
    end
    busy_force = 1'b1;
    @(negedge clk);
    chk("single_start_drop", {31'h0, start}, 32'h0);
    chk("single_idle_busy", {31'h0, idle}, 32'h0);
    busy_force = 1'b0;
    @(negedge clk);
    chk("single_idle", {31'h0, idle}, 32'h1);

    // Fill to full, then overflow
    busy_force = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      write_req = 1'b1;
      wr_data   = 8'(i);
      sb.push_back(8'(i));
    end
    @(negedge clk);
    chk("fill_full", {31'h0, full}, 32'h1);
    chk("fill_count", {28'h0, count}, 32'h8);
    chk("fill_ovf_pre", {31'h0, ovf}, 32'h0);
    wr_data = 8'hFF;
    @(negedge clk);
    write_req = 1'b0;
    chk("ovf_set", {31'h0, ovf}, 32'h1);
    chk("ovf_count", {28'h0, count}, 32'h8);
    chk("ovf_full", {31'h0, full}, 32'h1);
    busy_force = 1'b0;
    model_en   = 1'b1;
    wait_drain("fill_drain");
    chk("ovf_sticky", {31'h0, ovf}, 32'h1);
    chk("drain_empty", {31'h0, empty}, 32'h1);

    // Wrap-around: 20 rounds of 3 bytes
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        write_req = 1'b1;
        wr_data   = 8'(8'h10 + r * 3 + k);
        sb.push_back(8'(8'h10 + r * 3 + k));
      end
      @(negedge clk);
      write_req = 1'b0;
      wait_drain("wrap_drain");
    end
    chk("wrap_count", {28'h0, count}, 32'h0);

    // Simultaneous write and pop with two entries queued
    model_en   = 1'b0;
    busy_force = 1'b1;
    @(negedge clk);
    write_req = 1'b1;
    wr_data   = 8'hA1;
    sb.push_back(8'hA1);
    @(negedge clk);
    wr_data = 8'hA2;
    sb.push_back(8'hA2);
    @(negedge clk);
    chk("simul_count_pre", {28'h0, count}, 32'h2);
    busy_force = 1'b0;
    wr_data    = 8'h3C;
    sb.push_back(8'h3C);
    @(negedge clk);
    write_req = 1'b0;
    chk("simul_count", {28'h0, count}, 32'h2);
    chk("simul_start", {31'h0, start}, 32'h1);
    model_en = 1'b1;
    wait_drain("simul_drain");

    // Reset in START with five entries still queued
    model_en   = 1'b0;
    busy_force = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      write_req = 1'b1;
      wr_data   = 8'(8'hC0 + i);
      sb.push_back(8'(8'hC0 + i));
    end
    @(negedge clk);
    write_req  = 1'b0;
    busy_force = 1'b0;
    @(negedge clk);
    chk("mid_start", {31'h0, start}, 32'h1);
    chk("mid_count", {28'h0, count}, 32'h5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_start", {31'h0, start}, 32'h0);
    chk("mid_rst_count", {28'h0, count}, 32'h0);
    chk("mid_rst_empty", {31'h0, empty}, 32'h1);
    chk("mid_rst_ovf", {31'h0, ovf}, 32'h0);
    sb.delete();
    starts = 0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    model_en = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_rst_starts", starts, 32'h0);
    chk("post_rst_count", {28'h0, count}, 32'h0);
    chk("post_rst_idle", {31'h0, idle}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
